// File: rtl/cricket_pkg.sv
// Shared types and clock-derived constants for the cricket game input path.
// FSM state encoding used by the button conditioner and related sequencers.
package cricket_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam int CLK_HZ         = 100000000;
    localparam int CYCLES_PER_MS  = CLK_HZ / 1000;
    localparam int DEBOUNCE_10MS  = 10 * CYCLES_PER_MS;
    localparam int REPEAT_500MS   = 500 * CYCLES_PER_MS;
    localparam int REPEAT_250MS   = 250 * CYCLES_PER_MS;

    function automatic int ms_to_cycles(input int ms);
        return ms * CYCLES_PER_MS;
    endfunction

endpackage

// File: rtl/delivery_pulse_gen_if.sv
// Button pad bundle: raw press/lock towards the conditioner, clean strobe/status back.
interface delivery_pulse_gen_if;
    logic btn_raw;
    logic lock;
    logic delivery;
    logic btn_level;
    logic busy;

    modport master (output btn_raw, lock, input delivery, btn_level, busy);
    modport slave  (input btn_raw, lock, output delivery, btn_level, busy);
endinterface

// File: rtl/sync_ff.sv
// Reset-to-0 multi-flop synchroniser for an asynchronous level input.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_b,
    input  logic level,
    output logic synced
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_b) chain <= '0;
        else        chain <= {chain[STAGES-2:0], level};
    end

    assign synced = chain[STAGES-1];
endmodule

// File: rtl/delivery_pulse_gen.sv
// Push-button conditioner: synchronise, debounce, one delivery strobe per accepted press.
// Optional auto-repeat while held is enabled by defining DELIVERY_AUTOREPEAT_EN.
//
// state     | meaning
// IDLE      | button released and stable
// PRESS_CHK | counting consecutive pressed samples
// HELD      | press accepted, waiting for release
// REL_CHK   | counting consecutive released samples
module delivery_pulse_gen
    import cricket_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 25000000
) (
    input  logic                 clk_fpga,
    input  logic                 reset,
    delivery_pulse_gen_if.slave  pad
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s;
    logic          accept;
    logic          fire;
    logic          delivery_q, level_q, busy_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk_fpga),
        .rst_b  (reset),
        .level  (pad.btn_raw),
        .synced (s)
    );

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    // >= rather than == lets DEBOUNCE_CYCLES==1 exit on the first PRESS_CHK sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = REL_CHK;
                    cnt_d   = CW'(1);
                end
            end
            REL_CHK: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef DELIVERY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          first_q, first_d;
    logic          rpt_pulse;

    // Counter only advances while HELD sees the button down; REL_CHK freezes it.
    always_comb begin
        rpt_d     = rpt_q;
        first_d   = first_q;
        rpt_pulse = 1'b0;
        if (accept) begin
            rpt_d   = '0;
            first_d = 1'b1;
        end else if (state_q == HELD && s) begin
            if (rpt_q == (first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1))) begin
                rpt_pulse = 1'b1;
                rpt_d     = '0;
                first_d   = 1'b0;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            rpt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            rpt_q   <= rpt_d;
            first_q <= first_d;
        end
    end

    assign fire = (accept | rpt_pulse) & ~pad.lock;
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign fire           = accept & ~pad.lock;
`endif

    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            delivery_q <= 1'b0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            delivery_q <= fire;
            level_q    <= (state_d == HELD) || (state_d == REL_CHK);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign pad.delivery  = delivery_q;
    assign pad.btn_level = level_q;
    assign pad.busy      = busy_q;
endmodule

// File: tb/tb_delivery_pulse_gen.sv
// Scoreboard bench for delivery_pulse_gen: expected pulse cycles queued at stimulus time.
// Define DELIVERY_AUTOREPEAT_EN for both RTL and bench to cover auto-repeat.
module tb_delivery_pulse_gen;
    localparam int DEB = 4;
    localparam int SYN = 2;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic clk_fpga = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    int   exp_q[$];

    delivery_pulse_gen_if pad ();

    delivery_pulse_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYN),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .pad      (pad)
    );

    always #5 clk_fpga = ~clk_fpga;
    always @(posedge clk_fpga) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Queue the pulses a press should produce: the acceptance pulse plus any
    // auto-repeats up to the last cycle the FSM still sees the button down.
    task automatic push_train(input int acc, input int last_hi, input int lock_end);
        if (acc > lock_end) exp_q.push_back(acc);
`ifdef DELIVERY_AUTOREPEAT_EN
        begin
            int t;
            t = acc + RD;
            while (t <= last_hi) begin
                if (t > lock_end) exp_q.push_back(t);
                t += RP;
            end
        end
`endif
    endtask

    always @(negedge clk_fpga) begin
        if (mon_en) begin
            int e;
            e = (exp_q.size() > 0 && exp_q[0] == cyc) ? 1 : 0;
            chk("delivery", int'(pad.delivery), e);
            if (e == 1) void'(exp_q.pop_front());
            else if (exp_q.size() > 0 && exp_q[0] < cyc) void'(exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_fpga);
    endtask

    task automatic press_hold(input int hold, input int lock_len);
        int c0;
        c0 = cyc;
        pad.btn_raw = 1'b1;
        pad.lock    = (lock_len > 0);
        push_train(c0 + SYN + DEB, c0 + hold + SYN, c0 + lock_len);
        for (int i = 1; i <= hold + 8; i++) begin
            @(negedge clk_fpga);
            if (i == lock_len) pad.lock = 1'b0;
            if (i == hold) pad.btn_raw = 1'b0;
            if (i == 2) chk("busy_before_sample", int'(pad.busy), 0);
            if (i == 3) chk("busy_on_sample", int'(pad.busy), 1);
            if (i == 5) chk("level_before_accept", int'(pad.btn_level), 0);
            if (i == 6) chk("level_on_accept", int'(pad.btn_level), 1);
            if (i == hold / 2 + 3) chk("busy_held", int'(pad.busy), 1);
            if (i == hold + 5) chk("level_before_release", int'(pad.btn_level), 1);
            if (i == hold + 6) begin
                chk("level_released", int'(pad.btn_level), 0);
                chk("busy_released", int'(pad.busy), 0);
            end
        end
    endtask

    initial begin
        int c0, c1;
        reset       = 1'b0;
        pad.btn_raw = 1'b0;
        pad.lock    = 1'b0;
        idle(3);
        chk("rst_delivery", int'(pad.delivery), 0);
        chk("rst_level", int'(pad.btn_level), 0);
        chk("rst_busy", int'(pad.busy), 0);
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(4);

        // clean press, 20 cycles
        press_hold(20, 0);

        // glitch low on debounce cycle 2: counter restarts from the re-rise
        c0 = cyc;
        pad.btn_raw = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_fpga);
            if (i == 2) pad.btn_raw = 1'b0;
            if (i == 3) begin
                pad.btn_raw = 1'b1;
                push_train(cyc + SYN + DEB, c0 + 20 + SYN, 0);
            end
            if (i == 8) chk("glitch_level_low", int'(pad.btn_level), 0);
            if (i == 9) chk("glitch_level_high", int'(pad.btn_level), 1);
            if (i == 20) pad.btn_raw = 1'b0;
        end

        // 3-cycle raw pulses never survive debounce
        for (int k = 0; k < 5; k++) begin
            pad.btn_raw = 1'b1;
            idle(3);
            pad.btn_raw = 1'b0;
            idle(3);
            chk("short_level", int'(pad.btn_level), 0);
        end
        idle(6);
        chk("short_busy", int'(pad.busy), 0);

        // lock through acceptance, dropped mid-hold: no pulse
        press_hold(20, 10);
        // next press unlocked
        press_hold(12, 0);

        // reset mid-PRESS_CHK with button held through release of reset
        pad.btn_raw = 1'b1;
        idle(4);
        reset = 1'b0;
        idle(1);
        chk("rst_pchk_level", int'(pad.btn_level), 0);
        chk("rst_pchk_busy", int'(pad.busy), 0);
        chk("rst_pchk_delivery", int'(pad.delivery), 0);
        reset = 1'b1;
        c1 = cyc;
        push_train(c1 + SYN + DEB, c1 + 15 + SYN, 0);
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk_fpga);
            if (i == 5) chk("rerun_level_low", int'(pad.btn_level), 0);
            if (i == 6) chk("rerun_level_high", int'(pad.btn_level), 1);
            if (i == 15) pad.btn_raw = 1'b0;
        end

        // reset mid-HELD
        c0 = cyc;
        pad.btn_raw = 1'b1;
        push_train(c0 + SYN + DEB, c0 + 10, 0);
        idle(10);
        chk("held_level", int'(pad.btn_level), 1);
        reset = 1'b0;
        idle(1);
        chk("rst_held_level", int'(pad.btn_level), 0);
        chk("rst_held_busy", int'(pad.busy), 0);
        chk("rst_held_delivery", int'(pad.delivery), 0);
        reset = 1'b1;
        c1 = cyc;
        push_train(c1 + SYN + DEB, c1 + 15 + SYN, 0);
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk_fpga);
            if (i == 15) pad.btn_raw = 1'b0;
        end

        // long hold: auto-repeat train when enabled, single pulse otherwise
        press_hold(34, 0);
        idle(10);

        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/delivery_pulse_gen.md
Name: delivery_pulse_gen

Overview:
- Upstream conditioner for the bowler's up push button; feeds the single-cycle `delivery` strobe consumed by the game logic.
- Pipeline: synchronises the raw pad input, debounces it with a stability counter, then emits exactly one clean pulse per physical press.
- Adds a lock input so the top level can suppress deliveries while the game reports game-over.
- Replaces the ad-hoc debounce stage with a parameterised, verifiable FSM.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a level change (10 ms at 100 MHz).
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser (legal 2..4).
- REPEAT_DELAY, 50000000: hold time before the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 25000000: spacing between auto-repeat pulses (used only with the optional feature).

Ports:
- clk_fpga, input, 1: 100 MHz master clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-low reset; sampled on the clk_fpga rising edge.
- btn_raw, input, 1: asynchronous, bouncy push-button level (1 = pressed).
- lock, input, 1: when 1, pulses are suppressed; press/release tracking continues.
- delivery, output, 1: one-clock-cycle pulse per accepted press.
- btn_level, output, 1: debounced button level.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Synchroniser flops, counter and all outputs go to 0.
  - FSM goes to IDLE.
  - Takes effect the same edge, including mid-debounce or mid-hold; no pulse is emitted on the edge reset is released.
- Synchroniser: btn_raw passes through SYNC_STAGES flops; `s` denotes the last stage.
- Counter: width $clog2(DEBOUNCE_CYCLES+1); saturates, never wraps.
- FSM states:
  - IDLE:
    - s==1 -> go to PRESS_CHK, counter=1.
    - Otherwise stay; counter=0.
  - PRESS_CHK:
    - s==0 -> return to IDLE, counter=0 (bounce rejected).
    - s==1 and counter==DEBOUNCE_CYCLES-1 -> go to HELD, set btn_level=1, assert delivery for this transition edge only (if lock==0).
    - Otherwise counter++.
  - HELD:
    - s==0 -> go to REL_CHK, counter=1.
    - s==1 -> stay.
  - REL_CHK:
    - s==1 -> return to HELD, counter=0.
    - s==0 and counter==DEBOUNCE_CYCLES-1 -> go to IDLE, btn_level=0.
    - Otherwise counter++.
- Output timing:
  - delivery is registered; it is high exactly one cycle after the edge that sees the DEBOUNCE_CYCLES-th consecutive 1 on `s`.
  - Latency from a clean btn_raw rise to delivery high = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Pulse guarantees:
  - Never two deliveries without an intervening accepted release (absent the optional feature).
  - lock sampled high on the pulse edge -> the pulse is dropped, not deferred.
  - lock deasserting while in HELD does not produce a pulse.
- Edge cases:
  - DEBOUNCE_CYCLES==1: PRESS_CHK exits after one sample (legal).
  - A release bounce shorter than DEBOUNCE_CYCLES keeps the FSM in HELD/REL_CHK and produces no new pulse.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: DELIVERY_AUTOREPEAT_EN.
- Defined:
  - In HELD, a second counter (width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)) starts at 0 on entry.
  - When it reaches REPEAT_DELAY-1, one delivery pulse is emitted, the counter reloads to 0, and subsequent pulses occur every REPEAT_PERIOD cycles while held.
  - Entering REL_CHK freezes the counter; returning to HELD resumes it.
  - lock suppresses repeat pulses the same way as the initial pulse.
- Undefined: the second counter and its logic are absent; exactly one pulse per press.

Decomposition:
- Shared package `cricket_pkg`:
  - FSM state enum typedef (IDLE, PRESS_CHK, HELD, REL_CHK), 2-bit encoding.
  - Constant CLK_HZ=100000000.
  - Helper localparams for ms-to-cycles conversion.
- Sub-module `sync_ff` (parameter STAGES): the reset-to-0 synchroniser chain. It is natural to isolate and reusable for the sw input.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=5 for sim):
- Clean press held 20 cycles, then released -> delivery high for exactly 1 cycle, 6 cycles after the btn_raw rise; btn_level rises with it and falls 6 cycles after the release; busy high throughout.
- Press with a 1-cycle glitch low at cycle 2 of the debounce -> counter restarts; pulse is delayed accordingly; exactly 1 pulse total.
- Raw pulses 3 cycles wide, repeated -> zero deliveries; btn_level stays 0.
- lock=1 during an accepted press -> no delivery; btn_level still 1. Drop lock while held -> still no pulse. The next press with lock=0 -> 1 pulse.
- reset=0 asserted mid-PRESS_CHK and mid-HELD -> next edge shows state IDLE, all outputs 0. Hold btn_raw high across reset release -> the full debounce runs again and 1 pulse follows.
- DELIVERY_AUTOREPEAT_EN defined, hold 30 cycles past acceptance -> pulses at acceptance, +10, +15, +20, +25, +30 relative to HELD entry; none after release.
